// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM states, SPI mode encodings
// and the sck edge classification used by the clock generator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } state_t;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // LEAD_EDGE moves sck away from cpol (odd edges), TRAIL_EDGE returns it (even edges).
    typedef enum logic {
        LEAD_EDGE,
        TRAIL_EDGE
    } edge_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK timing: a CLK_DIV divider that paces every phase, plus an edge counter
// that classifies each sck edge of the data phase and flags the final one.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
)(
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  xfer_en,
    output logic  tick,
    output logic  edge_stb,
    output edge_t edge_kind,
    output logic  last_edge
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || !en || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Counts completed edges; cleared outside the data phase so it never wraps.
    always_ff @(posedge clk) begin
        if (reset || !xfer_en)
            edge_cnt <= '0;
        else if (edge_stb)
            edge_cnt <= edge_cnt + 1'b1;
    end

    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign edge_stb  = xfer_en && tick;
    assign edge_kind = edge_cnt[0] ? TRAIL_EDGE : LEAD_EDGE;
    assign last_edge = (edge_cnt == EDGE_W'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with run-time CPOL/CPHA and bit order, parametrised
// word width, slave-select count and sck divider.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  NUM_SS  = 3,
    parameter int  CLK_DIV = 2,
    localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              err
);

    state_t state_q, state_d;
    logic   cpha_q, lsb_q;
    logic [DATA_W-1:0] tx_shift, rx_shift;
    logic [NUM_SS-1:0] ss_dec;
    logic   ss_ok, accept, reject, shift_en, sample_en, done;
    logic   tick, edge_stb, last_edge;
    edge_t  edge_kind;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    spi_clk_gen #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (state_q != IDLE),
        .xfer_en   (state_q == XFER),
        .tick      (tick),
        .edge_stb  (edge_stb),
        .edge_kind (edge_kind),
        .last_edge (last_edge)
    );

    assign ss_ok = int'(ss_sel) < NUM_SS;
    assign busy  = (state_q != IDLE);

    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (int'(ss_sel) == i) ss_dec[i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start && ss_ok;
                reject = start && !ss_ok;
                if (accept) state_d = LEAD;
            end
            LEAD:  if (tick) state_d = XFER;
            XFER: begin
                // cpha=0 samples on leading edges, cpha=1 on trailing; shifting takes the other edge.
                sample_en = edge_stb && ((edge_kind == LEAD_EDGE) != cpha_q);
                shift_en  = edge_stb && ((edge_kind == LEAD_EDGE) == cpha_q) && !(last_edge && !cpha_q);
                if (edge_stb && last_edge) state_d = TRAIL;
            end
            TRAIL: begin
                done = tick;
                if (tick) state_d = GAP;
            end
            GAP:   if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck      <= 1'b0;
            mosi     <= 1'b1;
            ss_n     <= '1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rx_valid <= done;
            err      <= reject;
            if (state_q == IDLE) begin
                sck  <= mode[1];
                mosi <= 1'b1;
                ss_n <= '1;
                if (accept) begin
                    ss_n <= ss_dec;
                    if (!mode[0]) mosi <= head_bit(tx_data, lsb_first);
                end
            end
            if (edge_stb) sck <= ~sck;
            if (shift_en) mosi <= head_bit(tx_shift, lsb_q);
            if (done) begin
                ss_n    <= '1;
                mosi    <= 1'b1;
                rx_data <= rx_shift;
            end
        end
    end

    // NOTE: datapath registers carry no reset; their contents are only consumed after an accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            cpha_q   <= mode[0];
            lsb_q    <= lsb_first;
            tx_shift <= mode[0] ? tx_data : shift_word(tx_data, lsb_first);
        end else if (shift_en) begin
            tx_shift <= shift_word(tx_shift, lsb_q);
        end
        if (sample_en)
            rx_shift <= lsb_q ? {miso, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], miso};
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param with a behavioural SPI slave that drives
// miso and records mosi according to its own copy of the transfer mode.
module tb_spi_master_param;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = MODE0;
    logic       lsb_first = 1'b0;
    logic [1:0] ss_sel = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic       miso = 1'b0;
    logic       sck, mosi, busy, rx_valid, err;
    logic [2:0] ss_n;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_pass   = 0;

    spi_master_param #(.DATA_W(8), .NUM_SS(3), .CLK_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .lsb_first (lsb_first),
        .ss_sel    (ss_sel),
        .tx_data   (tx_data),
        .miso      (miso),
        .sck       (sck),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .busy      (busy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural slave, evaluated on the falling clk edge away from DUT updates.
    logic [1:0] sl_mode = MODE0;
    logic       sl_lsb = 1'b0;
    logic [7:0] sl_word = 8'h3C;
    logic [7:0] sl_rx = 8'h00;
    logic [7:0] rise_bits = 8'h00;
    int         sl_idx = 0;
    int         sck_toggles = 0;
    logic       prev_sck = 1'b0;
    logic       prev_act = 1'b0;

    task slave_present();
        if (sl_idx < 8) begin
            miso = sl_lsb ? sl_word[sl_idx] : sl_word[7 - sl_idx];
            sl_idx++;
        end
    endtask

    always @(negedge clk) begin
        logic act;
        logic lead;
        act = (ss_n != 3'b111);
        if (act && !prev_act) begin
            sl_idx = 0;
            sl_rx  = 8'h00;
            if (!sl_mode[0]) slave_present();
        end
        if (sck !== prev_sck) begin
            sck_toggles++;
            if (sck === 1'b1) rise_bits = {rise_bits[6:0], mosi};
            if (act) begin
                lead = (sck != sl_mode[1]);
                if (lead != sl_mode[0])
                    sl_rx = sl_lsb ? {mosi, sl_rx[7:1]} : {sl_rx[6:0], mosi};
                else
                    slave_present();
            end
        end
        prev_sck = sck;
        prev_act = act;
    end

    // Observations filled in by do_xfer.
    int         obs_lat, obs_ss_bad;
    logic       obs_idle_sck, obs_first_mosi, obs_valid_next;
    logic [7:0] obs_rx, obs_sl_rx, obs_rise;

    task automatic do_xfer(input logic [1:0] m, input logic lsb, input logic [1:0] sel,
                           input logic [7:0] tx, input logic [2:0] exp_ss);
        mode = m; lsb_first = lsb; ss_sel = sel; tx_data = tx;
        sl_mode = m; sl_lsb = lsb;
        repeat (2) @(posedge clk);
        #1;
        obs_idle_sck = sck;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        obs_first_mosi = mosi;
        obs_ss_bad = 0;
        obs_lat = -1;
        // Scramble the inputs mid-transfer; the latched copies must win.
        mode = ~m; lsb_first = ~lsb; ss_sel = sel + 2'd1; tx_data = ~tx;
        for (int n = 1; n <= 100; n++) begin
            if (rx_valid) begin
                obs_lat = n;
                break;
            end
            if (ss_n !== exp_ss) obs_ss_bad++;
            @(posedge clk); #1;
        end
        obs_rx = rx_data;
        obs_sl_rx = sl_rx;
        obs_rise = rise_bits;
        @(posedge clk); #1;
        obs_valid_next = rx_valid;
        mode = m;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", sck); else n_pass++;
        n_checks++; if (mosi !== 1'b1) $display("FAIL reset_mosi: got %b want 1", mosi); else n_pass++;
        n_checks++; if (ss_n !== 3'b111) $display("FAIL reset_ss_n: got %b want 111", ss_n); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mode0();
        sl_word = 8'h3C;
        do_xfer(MODE0, 1'b0, 2'd0, 8'hA5, 3'b110);
        n_checks++; if (obs_idle_sck !== 1'b0) $display("FAIL m0_idle_sck: got %b want 0", obs_idle_sck); else n_pass++;
        n_checks++; if (obs_first_mosi !== 1'b1) $display("FAIL m0_first_mosi: got %b want 1", obs_first_mosi); else n_pass++;
        n_checks++; if (obs_lat != 37) $display("FAIL m0_latency: got %0d want 37", obs_lat); else n_pass++;
        n_checks++; if (obs_rx !== 8'h3C) $display("FAIL m0_rx_data: got %h want 3c", obs_rx); else n_pass++;
        n_checks++; if (obs_ss_bad != 0) $display("FAIL m0_ss_n: %0d cycles differ from 110", obs_ss_bad); else n_pass++;
        n_checks++; if (obs_rise !== 8'hA5) $display("FAIL m0_mosi_on_rise: got %h want a5", obs_rise); else n_pass++;
        n_checks++; if (obs_sl_rx !== 8'hA5) $display("FAIL m0_slave_rx: got %h want a5", obs_sl_rx); else n_pass++;
        n_checks++; if (obs_valid_next !== 1'b0) $display("FAIL m0_valid_pulse: got %b want 0", obs_valid_next); else n_pass++;
        n_checks++; if (rx_data !== 8'h3C) $display("FAIL m0_rx_hold: got %h want 3c", rx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL m0_busy_idle: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_modes();
        sl_word = 8'h3C;
        for (int i = 1; i < 4; i++) begin
            logic [1:0] m;
            m = 2'(i);
            do_xfer(m, 1'b0, 2'd1, 8'hA5, 3'b101);
            n_checks++; if (obs_idle_sck !== m[1]) $display("FAIL mode%0d_idle_sck: got %b want %b", i, obs_idle_sck, m[1]); else n_pass++;
            n_checks++; if (obs_lat != 37) $display("FAIL mode%0d_latency: got %0d want 37", i, obs_lat); else n_pass++;
            n_checks++; if (obs_rx !== 8'h3C) $display("FAIL mode%0d_rx_data: got %h want 3c", i, obs_rx); else n_pass++;
            n_checks++; if (obs_sl_rx !== 8'hA5) $display("FAIL mode%0d_slave_rx: got %h want a5", i, obs_sl_rx); else n_pass++;
            n_checks++; if (obs_ss_bad != 0) $display("FAIL mode%0d_ss_n: %0d cycles differ from 101", i, obs_ss_bad); else n_pass++;
        end
    endtask

    task automatic test_lsb_first();
        sl_word = 8'h01;
        do_xfer(MODE0, 1'b1, 2'd2, 8'h01, 3'b011);
        n_checks++; if (obs_first_mosi !== 1'b1) $display("FAIL lsb_first_mosi: got %b want 1", obs_first_mosi); else n_pass++;
        n_checks++; if (obs_ss_bad != 0) $display("FAIL lsb_ss_n: %0d cycles differ from 011", obs_ss_bad); else n_pass++;
        n_checks++; if (obs_rx !== 8'h01) $display("FAIL lsb_rx_data: got %h want 01", obs_rx); else n_pass++;
        n_checks++; if (obs_sl_rx !== 8'h01) $display("FAIL lsb_slave_rx: got %h want 01", obs_sl_rx); else n_pass++;
        n_checks++; if (obs_lat != 37) $display("FAIL lsb_latency: got %0d want 37", obs_lat); else n_pass++;
    endtask

    task automatic test_bad_sel();
        int tgl0;
        mode = MODE0; ss_sel = 2'd3; tx_data = 8'h5A;
        @(posedge clk); #1;
        tgl0 = sck_toggles;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (err !== 1'b1) $display("FAIL badsel_err: got %b want 1", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL badsel_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (ss_n !== 3'b111) $display("FAIL badsel_ss_n: got %b want 111", ss_n); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (err !== 1'b0) $display("FAIL badsel_err_pulse: got %b want 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL badsel_busy_after: got %b want 0", busy); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sck_toggles != tgl0) $display("FAIL badsel_sck: %0d toggles want 0", sck_toggles - tgl0); else n_pass++;
        n_checks++; if (ss_n !== 3'b111) $display("FAIL badsel_ss_n_after: got %b want 111", ss_n); else n_pass++;
        ss_sel = 2'd0;
    endtask

    task automatic test_back_to_back();
        int v1, v2, hi, lo_busy, errs, nvalid;
        logic [7:0] rx1, rx2, slr1, slr2;
        mode = MODE0; lsb_first = 1'b0; ss_sel = 2'd0; tx_data = 8'hFF;
        sl_mode = MODE0; sl_lsb = 1'b0; sl_word = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        v1 = -1; v2 = -1; hi = 0; lo_busy = 0; errs = 0; nvalid = 0;
        rx1 = 8'h00; rx2 = 8'h00; slr1 = 8'h00; slr2 = 8'h00;
        start = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            @(posedge clk); #1;
            if (n == 1) tx_data = 8'h00;
            if (n == 45) start = 1'b0;
            if (n >= 50 && n < 70) start = 1'(n % 2);
            if (n == 70) start = 1'b0;
            if (rx_valid) begin
                nvalid++;
                if (v1 < 0) begin v1 = n; rx1 = rx_data; slr1 = sl_rx; end
                else begin v2 = n; rx2 = rx_data; slr2 = sl_rx; end
            end
            if (n >= 2 && n <= 75 && ss_n == 3'b111) hi++;
            if (n <= 75 && !busy) lo_busy++;
            if (err) errs++;
        end
        n_checks++; if (v1 != 37) $display("FAIL b2b_first_valid: got %0d want 37", v1); else n_pass++;
        n_checks++; if (v2 != 76) $display("FAIL b2b_second_valid: got %0d want 76", v2); else n_pass++;
        n_checks++; if (rx1 !== 8'h3C) $display("FAIL b2b_rx1: got %h want 3c", rx1); else n_pass++;
        n_checks++; if (rx2 !== 8'h3C) $display("FAIL b2b_rx2: got %h want 3c", rx2); else n_pass++;
        n_checks++; if (slr1 !== 8'hFF) $display("FAIL b2b_slave_rx1: got %h want ff", slr1); else n_pass++;
        n_checks++; if (slr2 !== 8'h00) $display("FAIL b2b_slave_rx2: got %h want 00", slr2); else n_pass++;
        n_checks++; if (hi != 3) $display("FAIL b2b_ss_gap: got %0d cycles want 3", hi); else n_pass++;
        n_checks++; if (lo_busy != 1) $display("FAIL b2b_idle_cycles: got %0d want 1", lo_busy); else n_pass++;
        n_checks++; if (nvalid != 2) $display("FAIL b2b_valid_count: got %0d want 2", nvalid); else n_pass++;
        n_checks++; if (errs != 0) $display("FAIL b2b_err: got %0d pulses want 0", errs); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_final_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int tgl0, nvalid;
        mode = MODE2; lsb_first = 1'b0; ss_sel = 2'd0; tx_data = 8'hA5;
        sl_mode = MODE2; sl_lsb = 1'b0; sl_word = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        tgl0 = sck_toggles;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_checks++; if (sck_toggles - tgl0 != 6) $display("FAIL rst_mid_edges: got %0d want 6", sck_toggles - tgl0); else n_pass++;
        n_checks++; if (sck !== 1'b1) $display("FAIL rst_mid_sck_before: got %b want 1", sck); else n_pass++;
        n_checks++; if (mosi !== 1'b0) $display("FAIL rst_mid_mosi_before: got %b want 0", mosi); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", busy); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (ss_n !== 3'b111) $display("FAIL rst_mid_ss_n: got %b want 111", ss_n); else n_pass++;
        n_checks++; if (sck !== 1'b0) $display("FAIL rst_mid_sck: got %b want 0", sck); else n_pass++;
        n_checks++; if (mosi !== 1'b1) $display("FAIL rst_mid_mosi: got %b want 1", mosi); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL rst_mid_rx_data: got %h want 00", rx_data); else n_pass++;
        nvalid = 0;
        for (int n = 0; n < 60; n++) begin
            if (rx_valid) nvalid++;
            @(posedge clk); #1;
        end
        n_checks++; if (nvalid != 0) $display("FAIL rst_mid_no_valid: got %0d pulses want 0", nvalid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_lsb_first();
        test_bad_sel();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
